// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: EX/MEM request, data-RAM bus and load-result bundle for the MEM-stage LSU.
// master: pipeline/RAM side; slave: the load/store unit.
interface mem_stage_lsu_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    // EX/MEM request
    logic                  ex_mem_valid;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic [1:0]            ex_mem_size;
    logic                  ex_mem_unsigned;
    logic [31:0]           ex_mem_addr;
    logic [31:0]           ex_mem_wdata;

    // Synchronous data RAM
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [3:0]            ram_be;
    logic                  ram_we;
    logic                  ram_re;
    logic [31:0]           ram_rdata;

    // Results towards MEM/WB and the hazard unit
    logic [31:0]           load_data;
    logic                  load_valid;
    logic                  mem_stall;
    logic                  misaligned;

    modport master (
        output ex_mem_valid, ex_mem_read, ex_mem_write, ex_mem_size, ex_mem_unsigned,
               ex_mem_addr, ex_mem_wdata, ram_rdata,
        input  ram_addr, ram_wdata, ram_be, ram_we, ram_re,
               load_data, load_valid, mem_stall, misaligned
    );

    modport slave (
        input  ex_mem_valid, ex_mem_read, ex_mem_write, ex_mem_size, ex_mem_unsigned,
               ex_mem_addr, ex_mem_wdata, ram_rdata,
        output ram_addr, ram_wdata, ram_be, ram_we, ram_re,
               load_data, load_valid, mem_stall, misaligned
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit. Byte-enabled stores, sign/zero-extended loads,
// synchronous data RAM plus memory-mapped switches, buttons and LED register.
// Optional feature: define MEM_STAGE_BUTTON_EDGE_EN for sticky button rising-edge latches
// readable (and cleared) at FFFF000C; otherwise that address reads 0.
module mem_stage_lsu #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst,
    mem_stage_lsu_if.slave bus,
    input  logic [9:0]     switches,
    input  logic           button0,
    input  logic           button1,
    output logic [31:0]    leds
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    // RAM_LATENCY is 1..4, so the wait counter never exceeds 3.
    localparam logic [1:0] CntInit = 2'(RAM_LATENCY - 1);

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic [31:0] load_data_q;
    logic        load_valid_q;
    logic [31:0] leds_q;
    logic [1:0]  btn_meta_q;
    logic [1:0]  btn_s_q;

    logic [31:0] addr;
    logic        is_io;
    logic [13:0] io_idx;
    logic        sz_byte;
    logic        sz_half;
    logic        misal;
    logic        idle;
    logic        acc_load;
    logic        acc_store;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] io_rdata;
    logic [1:0]  edge_rd;
    logic        led_we;

    // Select and extend the addressed byte/half of a fetched word.
    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   fmt_load = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   fmt_load = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: fmt_load = w;
        endcase
    endfunction

    // Request decode: region, size, alignment and whether this cycle accepts an op.
    always_comb begin
        addr      = bus.ex_mem_addr;
        is_io     = (addr[31:16] == 16'hFFFF);
        io_idx    = addr[15:2];
        sz_byte   = (bus.ex_mem_size == 2'b00);
        sz_half   = (bus.ex_mem_size == 2'b01);
        misal     = (sz_half && addr[0]) || (!sz_byte && !sz_half && (addr[1:0] != 2'b00));
        idle      = (state_q == StIdle);
        // Read wins when both read and write are set.
        acc_load  = idle && bus.ex_mem_valid && bus.ex_mem_read;
        acc_store = idle && bus.ex_mem_valid && bus.ex_mem_write && !bus.ex_mem_read;
    end

    // Byte enables and lane-replicated store data.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = bus.ex_mem_wdata;
        if (sz_byte) begin
            be        = 4'b0001 << addr[1:0];
            wdata_rep = {4{bus.ex_mem_wdata[7:0]}};
        end else if (sz_half) begin
            be        = addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{bus.ex_mem_wdata[15:0]}};
        end else begin
            be        = 4'b1111;
        end
    end

`ifdef MEM_STAGE_BUTTON_EDGE_EN
    logic [1:0] btn_prev_q;
    logic [1:0] edge_q;
    logic [1:0] rise;
    logic       edge_clr;

    // Rising edges of the synchronized buttons; clear on a completed read of FFFF000C.
    always_comb begin
        rise     = btn_s_q & ~btn_prev_q;
        edge_clr = (state_q == StDone) && bus.ex_mem_valid && bus.ex_mem_read && is_io &&
                   !misal && (io_idx == 14'd3);
        // Include this cycle's rise so an edge landing on the capture cycle is not lost.
        edge_rd  = edge_q | rise;
    end

    // Sticky edge latches; a new edge beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev_q <= 2'b00;
            edge_q     <= 2'b00;
        end else begin
            btn_prev_q <= btn_s_q;
            edge_q     <= (edge_q & ~{2{edge_clr}}) | rise;
        end
    end
`else
    // No edge latches in this build.
    always_comb begin
        edge_rd = 2'b00;
    end
`endif

    // Memory-mapped I/O read mux.
    always_comb begin
        io_rdata = 32'h0;
        case (io_idx)
            14'd0:   io_rdata = {22'b0, switches};
            14'd1:   io_rdata = {30'b0, btn_s_q};
            14'd2:   io_rdata = leds_q;
            14'd3:   io_rdata = {30'b0, edge_rd};
            default: io_rdata = 32'h0;
        endcase
    end

    // RAM strobes and accept-cycle pulses; all forced low while reset is held.
    always_comb begin
        bus.ram_addr   = addr[ADDR_WIDTH+1:2];
        bus.ram_wdata  = wdata_rep;
        bus.ram_be     = be;
        bus.ram_we     = !rst && acc_store && !is_io && !misal;
        bus.ram_re     = !rst && acc_load && !is_io && !misal;
        bus.misaligned = !rst && (acc_load || acc_store) && misal;
        bus.mem_stall  = !rst && (acc_load || (state_q == StWait));
        bus.load_data  = load_data_q;
        bus.load_valid = load_valid_q;
        leds           = leds_q;
        led_we         = acc_store && is_io && !misal && (io_idx == 14'd2);
    end

    // Load FSM: IDLE accepts, WAIT counts down RAM latency, DONE presents the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 2'd0;
            load_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (acc_load) begin
                        if (misal) begin
                            load_data_q  <= 32'h0;
                            load_valid_q <= 1'b1;
                            state_q      <= StDone;
                        end else if (is_io) begin
                            load_data_q  <= fmt_load(io_rdata, addr[1:0], bus.ex_mem_size,
                                                     bus.ex_mem_unsigned);
                            load_valid_q <= 1'b1;
                            state_q      <= StDone;
                        end else begin
                            cnt_q   <= CntInit;
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        load_data_q  <= fmt_load(bus.ram_rdata, addr[1:0], bus.ex_mem_size,
                                                 bus.ex_mem_unsigned);
                        load_valid_q <= 1'b1;
                        state_q      <= StDone;
                    end
                end
                StDone: begin
                    // EX/MEM still shows the finished op here; ignore it.
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // LED register, written per byte lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_q <= 32'h0;
        end else if (led_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) leds_q[i*8 +: 8] <= wdata_rep[i*8 +: 8];
            end
        end
    end

    // Two-flop synchronizers for the asynchronous buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q <= 2'b00;
            btn_s_q    <= 2'b00;
        end else begin
            btn_meta_q <= {button1, button0};
            btn_s_q    <= btn_meta_q;
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the five-stage MIPS pipeline. It sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. It turns EX/MEM memory requests into byte-enabled accesses to the synchronous data RAM or to memory-mapped board I/O (switches, buttons, LEDs). It sign/zero-extends load data and freezes the pipeline with `mem_stall` while a load is in flight.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: word-address width of the data RAM (1024 words).
- `RAM_LATENCY`, 1: cycles from `ram_re` to valid `ram_rdata`; legal range 1–4.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ex_mem_valid` in 1: a memory op is present in EX/MEM.
- `ex_mem_read` in 1: load.
- `ex_mem_write` in 1: store.
- `ex_mem_size` in 2: access size; 00 byte, 01 half, 10 word, 11 treated as word.
- `ex_mem_unsigned` in 1: zero-extend the load (LBU/LHU).
- `ex_mem_addr` in 32: byte address.
- `ex_mem_wdata` in 32: store data, right-justified.
- `ram_addr` out ADDR_WIDTH: word address, equal to `ex_mem_addr[ADDR_WIDTH+1:2]`.
- `ram_wdata` out 32: lane-replicated store data.
- `ram_be` out 4: byte enables.
- `ram_we` out 1: RAM write strobe.
- `ram_re` out 1: RAM read strobe.
- `ram_rdata` in 32: RAM read data.
- `switches` in 10: board switches.
- `button0`, `button1` in 1: asynchronous board buttons.
- `leds` out 32: LED register.
- `load_data` out 32: extended load result, to MEM/WB.
- `load_valid` out 1: one-cycle pulse, `load_data` is valid.
- `mem_stall` out 1: holds PC, IF/ID, ID/EX and EX/MEM.
- `misaligned` out 1: one-cycle pulse on an illegal alignment.

## Operation
- Address decode:
  - `addr[31:16]==16'hFFFF` selects I/O; otherwise the access goes to RAM.
  - I/O map: `FFFF0000` switches (read-only, zero-extended); `FFFF0004` `{30'b0,btn1_s,btn0_s}` (read-only); `FFFF0008` LED register (read/write); `FFFF000C` see Configuration.
  - Unmapped I/O addresses read 0 and ignore writes.
- Buttons: each passes through a 2-flop synchronizer; reads return the synchronized values `btn*_s`.
- Lanes are little-endian; the byte lane is `addr[1:0]`.
  - Byte: `be = 1<<addr[1:0]`, `wdata = {4{wdata[7:0]}}`.
  - Half: `be = addr[1] ? 1100 : 0011`, `wdata = {2{wdata[15:0]}}`.
  - Word: `be = 1111`.
  - LED stores apply the same byte enables to the LED register.
- Misaligned accesses are a half with `addr[0]=1` or a word with `addr[1:0]≠0`.
  - No RAM strobe and no LED update.
  - `misaligned` pulses in the accept cycle.
  - A misaligned load completes normally with `load_data = 0`.
- If `ex_mem_read` and `ex_mem_write` are both asserted, the op is treated as a load and the write is ignored.
- FSM states: IDLE, WAIT, DONE.
  - **IDLE:**
    - A valid store completes in that cycle: `ram_we`/`ram_be` combinational, or the LED update at the edge. No stall.
    - A valid RAM load asserts `ram_re` and `mem_stall`, loads the counter with `RAM_LATENCY-1`, and moves to WAIT.
    - A valid I/O or misaligned load asserts `mem_stall`, captures the formatted value at the edge, and moves to DONE.
  - **WAIT:** `mem_stall=1`. While the counter is nonzero it decrements. At zero, the formatted `ram_rdata` is captured into `load_data` and the FSM moves to DONE.
  - **DONE:** `mem_stall=0`, `load_valid=1`. EX/MEM inputs are ignored in this cycle because they still show the finished op. The FSM returns to IDLE.
- Load formatting: select the byte or half by `addr[1:0]`, then sign-extend, or zero-extend when `ex_mem_unsigned`.
- EX/MEM inputs are held stable by the pipeline while `mem_stall=1`; the block does not re-register them.

## Timing
- Reset values: state IDLE; `leds`, `load_data` and the synchronizers all 0; `load_valid`, `mem_stall`, `ram_we`, `ram_re` and `misaligned` all 0.
- RAM load accepted in cycle T:
  - `ram_re` is high in cycle T only.
  - `mem_stall` is high from T through T+RAM_LATENCY.
  - `load_valid` is high in T+RAM_LATENCY+1.
  - The load therefore costs RAM_LATENCY+1 stall cycles.
- I/O load accepted in T: `mem_stall` is high in T only; `load_valid` is high in T+1.
- Stores: zero stall cycles. The LED value is visible the cycle after the accept.
- A button edge is visible in a read 2–3 cycles after the pin changes.
- Reset asserted mid-load: the FSM goes to IDLE immediately, with no `load_valid` and no RAM strobe.
- Back-to-back loads: a new load is accepted no earlier than the cycle after DONE.

## Configuration
- `MEM_STAGE_BUTTON_EDGE_EN` defined:
  - Adds per-button rising-edge latches on the synchronized buttons.
  - `FFFF000C` reads `{30'b0,edge1,edge0}`; the read clears both latches at DONE.
  - If an edge arrives in the same cycle as the clearing read, the latch remains set.
- Not defined: no latches; `FFFF000C` reads 0.

## Test plan
- RAM word load, `RAM_LATENCY=2`, addr `0x40`, RAM returns `0x80FF1234` → `ram_addr=0x10`; `mem_stall` high for 3 cycles; `load_valid` high in the next cycle with `load_data=0x80FF1234`.
- LB/LBU at addr `0x43` from word `0x80FF1234` → LB returns `0xFFFFFF80`; LBU returns `0x00000080`.
- SH of `0xBEEF` at addr `0x22` → `ram_be=1100`, `ram_wdata=0xBEEFBEEF`, `ram_we` high for 1 cycle, no stall.
- SW of `0xA5A5A5A5` to `FFFF0008`, then LW from `FFFF0008` → `leds=0xA5A5A5A5` the next cycle; the load returns `0xA5A5A5A5` after a 1-cycle stall.
- LW at addr `0x42` → `misaligned` pulses; no `ram_re`; `load_data=0`; `load_valid` pulses.
- With `MEM_STAGE_BUTTON_EDGE_EN`: pulse `button1`, read `FFFF000C` twice → first read returns `0x2`, second returns `0x0`; assert `rst` mid-load → no `load_valid` and all outputs return to reset values.
